prbs_ber_checker: RTL and testbench
===================================

# prbs_ber_checker

Multi-channel, self-synchronising PRBS bit-error-rate checker for the receive side of the baseband link. It takes hard-decided bits per channel (I, Q, or more), one strobe per baud. It aligns a local PRBS reference to each incoming stream, then counts checked bits and bit errors per channel. Software and benches read the counters to measure BER against the transmitter PRBS after the noise channel, replacing file-based post-processing.

## Interface
- `NCH`, 2: number of independent channels.
- `PRBS_ORDER`, 9: PRBS polynomial. Legal values and polynomials:
  - 7: x^7+x^6+1
  - 9: x^9+x^5+1
  - 15: x^15+x^14+1
  - 23: x^23+x^18+1
  - 31: x^31+x^28+1
- `SYNC_LEN`, 32: consecutive correct predictions required to declare lock.
- `WINDOW`, 1024: length of the error-monitoring window, in checked bits.
- `ERR_THR`, 64: errors within one window above which lock is lost.
- `NB_CNT`, 32: width of each bit counter and each error counter.

Ports:
- `clk`  in  1  system clock.
- `i_reset`  in  1  asynchronous, active-high reset.
- `i_valid`  in  1  baud strobe; `i_bit` is sampled only when this is high.
- `i_bit`  in  NCH  received hard bits; bit k belongs to channel k.
- `i_clear`  in  1  synchronous clear of all counters and window state; does not affect lock.
- `o_lock`  out  NCH  per-channel lock flag.
- `o_bit_cnt`  out  NCH*NB_CNT  checked-bit counters; channel k occupies `[k*NB_CNT +: NB_CNT]`.
- `o_err_cnt`  out  NCH*NB_CNT  error counters, packed the same way.

## Operation
- Each channel runs its own `PRBS_ORDER`-bit LFSR `s` and its own FSM. Channels share nothing except `i_valid` and `i_clear`.
- Predicted bit: `p = s[ORDER-1] ^ s[TAP-1]`. Shift rule: `s <= {s[ORDER-2:0], b}`.
- FSM states are evaluated only on cycles where `i_valid` = 1:
  - **SEARCH**
    - b = `i_bit`; the received bit is shifted into the LFSR.
    - Load counter increments.
    - When the load counter reaches `PRBS_ORDER`, go to VERIFY with the correct-counter at 0.
  - **VERIFY**
    - b = p; the LFSR free-runs.
    - If `i_bit` == p, the correct-counter increments. When it reaches `SYNC_LEN`, go to LOCKED and clear the window counters.
    - If `i_bit` != p, go to SEARCH with the load counter at 0.
  - **LOCKED**
    - b = p.
    - Each valid bit increments `bit_cnt`. A mismatch also increments `err_cnt` and the window error counter.
    - At the end of a `WINDOW`-bit window, both window counters reset to 0.
- Lock loss:
  - Triggered when the window error counter exceeds `ERR_THR`; the check is made as the counter is updated.
  - Effect: go to SEARCH and deassert lock. Active only with the macro in Configuration.
- Counter rules:
  - `bit_cnt` and `err_cnt` saturate at all-ones and never wrap.
  - They are held, not cleared, when lock is lost.
- `i_clear` behaviour:
  - Clears `bit_cnt`, `err_cnt` and the window counters.
  - If it coincides with a valid bit in LOCKED, the clear wins and that bit is not counted.
- An all-zero LFSR state is not special-cased. An all-zero input stream self-syncs to the zero state and locks.

## Timing
- Reset values:
  - FSM in SEARCH; LFSR, load, correct and window counters at 0.
  - `o_lock` = 0; `o_bit_cnt` = 0; `o_err_cnt` = 0.
- All outputs are registered and update on the clock edge that samples `i_valid` = 1.
- Lock latency: on an error-free stream, `o_lock` rises on the edge that samples valid bit number `PRBS_ORDER + SYNC_LEN`. With defaults this is bit 41.
- `o_lock` falls on the edge that samples the error pushing the window count to `ERR_THR + 1`.
- Reset mid-operation takes effect immediately and asynchronously, and returns all state to reset values.
- `i_valid` may be high on back-to-back cycles. No minimum spacing is required.

## Configuration
- Macro: `BERCHK_AUTO_RESYNC_EN`.
- Defined: the window threshold check is active, and LOCKED → SEARCH occurs as described.
- Undefined: the window logic is not synthesised. LOCKED is sticky until `i_reset`. `WINDOW` and `ERR_THR` are ignored.

## Test plan
- **Clean lock.** Defaults; feed a PRBS9 stream from seed `9'h1AA` (ch0) and `9'h1FE` (ch1), `i_valid` every 4th cycle.
  - `o_lock` = 2'b11 after valid bit 41.
  - After a further 1000 bits: `bit_cnt` = 1000 and `err_cnt` = 0 on both channels.
- **Single error.** After lock, invert one ch0 bit.
  - ch0 `err_cnt` = 1 and lock is held.
  - ch1 is unaffected.
- **Burst loss and relock (macro defined).** Invert 65 consecutive ch0 bits inside one window.
  - ch0 `o_lock` falls on the 65th error; ch0 counters hold.
  - ch0 relocks 41 clean bits after the burst ends.
- **Sticky lock (macro undefined).** Same burst as above.
  - ch0 `o_lock` stays 1.
  - ch0 `err_cnt` ≈ 65 plus the subsequent mismatches.
- **Clear, VERIFY error, reset.**
  - `i_clear` while locked: counters go to 0 and `o_lock` stays 1.
  - A bit error during VERIFY returns the channel to SEARCH; lock appears 41 bits after that error.
  - `i_reset` mid-run: all outputs are 0 immediately, without waiting for a clock edge.
- **Saturation.** `NB_CNT` = 4 with a 20-bit clean run after lock: `bit_cnt` = 4'hF and stays there.

Source files
------------

// File: rtl/prbs_ber_checker.sv
// prbs_ber_checker: multi-channel self-synchronising PRBS bit-error-rate checker.
// Each channel loads its reference LFSR from the received stream, verifies the
// alignment over SYNC_LEN predictions, then counts checked bits and bit errors.
// Optional feature macro: BERCHK_AUTO_RESYNC_EN enables windowed error
// monitoring with automatic loss of lock. Without it, LOCKED is sticky.
module prbs_ber_checker #(
  parameter int NCH        = 2,
  parameter int PRBS_ORDER = 9,
  parameter int SYNC_LEN   = 32,
  parameter int WINDOW     = 1024,
  parameter int ERR_THR    = 64,
  parameter int NB_CNT     = 32
) (
  input  logic                  clk,
  input  logic                  i_reset,
  input  logic                  i_valid,
  input  logic [NCH-1:0]        i_bit,
  input  logic                  i_clear,
  output logic [NCH-1:0]        o_lock,
  output logic [NCH*NB_CNT-1:0] o_bit_cnt,
  output logic [NCH*NB_CNT-1:0] o_err_cnt
);

  // Second feedback tap (1-based) of the supported PRBS polynomials.
  function automatic int prbs_tap(input int order);
    case (order)
      7:       return 6;
      9:       return 5;
      15:      return 14;
      23:      return 18;
      31:      return 28;
      default: return 5;
    endcase
  endfunction

  localparam int TAP  = prbs_tap(PRBS_ORDER);
  localparam int LD_W = $clog2(PRBS_ORDER + 1);
  localparam int VF_W = $clog2(SYNC_LEN + 1);

  localparam logic [LD_W-1:0]   LD_LAST  = LD_W'(PRBS_ORDER - 1);
  localparam logic [LD_W-1:0]   LD_ONE   = LD_W'(1);
  localparam logic [VF_W-1:0]   VF_LAST  = VF_W'(SYNC_LEN - 1);
  localparam logic [VF_W-1:0]   VF_ONE   = VF_W'(1);
  localparam logic [NB_CNT-1:0] CNT_MAX  = {NB_CNT{1'b1}};
  localparam logic [NB_CNT-1:0] CNT_ONE  = NB_CNT'(1);
  localparam logic [NB_CNT-1:0] CNT_ZERO = {NB_CNT{1'b0}};

`ifdef BERCHK_AUTO_RESYNC_EN
  localparam int WB_W = $clog2(WINDOW);
  localparam int WE_W = $clog2(ERR_THR + 2);

  localparam logic [WB_W-1:0] WB_LAST = WB_W'(WINDOW - 1);
  localparam logic [WB_W-1:0] WB_ONE  = WB_W'(1);
  localparam logic [WE_W-1:0] WE_THR  = WE_W'(ERR_THR);
`endif

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    state_t                state_r;
    logic [PRBS_ORDER-1:0] lfsr_r;
    logic [LD_W-1:0]       load_cnt_r;
    logic [VF_W-1:0]       good_cnt_r;
    logic                  lock_r;
    logic [NB_CNT-1:0]     bit_cnt_r;
    logic [NB_CNT-1:0]     err_cnt_r;
    logic                  rx_s;
    logic                  pred_s;
    logic                  miss_s;

    assign rx_s   = i_bit[k];
    assign pred_s = lfsr_r[PRBS_ORDER-1] ^ lfsr_r[TAP-1];
    assign miss_s = rx_s ^ pred_s;

`ifdef BERCHK_AUTO_RESYNC_EN
    logic [WB_W-1:0] win_bit_r;
    logic [WE_W-1:0] win_err_r;
    logic [WE_W-1:0] win_err_nxt_s;
    logic            win_lost_s;

    // Lock loss is judged on the window error count including the current bit.
    assign win_err_nxt_s = win_err_r + WE_W'(miss_s);
    assign win_lost_s    = (win_err_nxt_s > WE_THR);
`endif

    // Per-channel alignment FSM, reference LFSR and saturating counters.
    always_ff @(posedge clk or posedge i_reset) begin
      if (i_reset) begin
        state_r    <= ST_SEARCH;
        lfsr_r     <= {PRBS_ORDER{1'b0}};
        load_cnt_r <= {LD_W{1'b0}};
        good_cnt_r <= {VF_W{1'b0}};
        lock_r     <= 1'b0;
        bit_cnt_r  <= CNT_ZERO;
        err_cnt_r  <= CNT_ZERO;
`ifdef BERCHK_AUTO_RESYNC_EN
        win_bit_r  <= {WB_W{1'b0}};
        win_err_r  <= {WE_W{1'b0}};
`endif
      end else begin
        if (i_valid) begin
          case (state_r)
            ST_SEARCH: begin
              // Received bits fill the reference register directly.
              lfsr_r <= {lfsr_r[PRBS_ORDER-2:0], rx_s};
              if (load_cnt_r == LD_LAST) begin
                state_r    <= ST_VERIFY;
                load_cnt_r <= {LD_W{1'b0}};
                good_cnt_r <= {VF_W{1'b0}};
              end else begin
                load_cnt_r <= load_cnt_r + LD_ONE;
              end
            end
            ST_VERIFY: begin
              lfsr_r <= {lfsr_r[PRBS_ORDER-2:0], pred_s};
              if (miss_s) begin
                state_r    <= ST_SEARCH;
                load_cnt_r <= {LD_W{1'b0}};
              end else if (good_cnt_r == VF_LAST) begin
                state_r <= ST_LOCKED;
                lock_r  <= 1'b1;
`ifdef BERCHK_AUTO_RESYNC_EN
                win_bit_r <= {WB_W{1'b0}};
                win_err_r <= {WE_W{1'b0}};
`endif
              end else begin
                good_cnt_r <= good_cnt_r + VF_ONE;
              end
            end
            ST_LOCKED: begin
              // Reference free-runs so alignment survives errored bits.
              lfsr_r <= {lfsr_r[PRBS_ORDER-2:0], pred_s};
              if (!i_clear) begin
                if (bit_cnt_r != CNT_MAX) begin
                  bit_cnt_r <= bit_cnt_r + CNT_ONE;
                end else begin
                  bit_cnt_r <= bit_cnt_r;
                end
                if (miss_s && (err_cnt_r != CNT_MAX)) begin
                  err_cnt_r <= err_cnt_r + CNT_ONE;
                end else begin
                  err_cnt_r <= err_cnt_r;
                end
`ifdef BERCHK_AUTO_RESYNC_EN
                if (win_lost_s) begin
                  state_r    <= ST_SEARCH;
                  lock_r     <= 1'b0;
                  load_cnt_r <= {LD_W{1'b0}};
                  win_bit_r  <= {WB_W{1'b0}};
                  win_err_r  <= {WE_W{1'b0}};
                end else if (win_bit_r == WB_LAST) begin
                  win_bit_r <= {WB_W{1'b0}};
                  win_err_r <= {WE_W{1'b0}};
                end else begin
                  win_bit_r <= win_bit_r + WB_ONE;
                  win_err_r <= win_err_nxt_s;
                end
`endif
              end
            end
            default: begin
              state_r    <= ST_SEARCH;
              lock_r     <= 1'b0;
              load_cnt_r <= {LD_W{1'b0}};
            end
          endcase
        end
        // Clear overrides any counting on the same edge; lock is untouched.
        if (i_clear) begin
          bit_cnt_r <= CNT_ZERO;
          err_cnt_r <= CNT_ZERO;
`ifdef BERCHK_AUTO_RESYNC_EN
          win_bit_r <= {WB_W{1'b0}};
          win_err_r <= {WE_W{1'b0}};
`endif
        end
      end
    end

    assign o_lock[k]                     = lock_r;
    assign o_bit_cnt[k*NB_CNT +: NB_CNT] = bit_cnt_r;
    assign o_err_cnt[k*NB_CNT +: NB_CNT] = err_cnt_r;
  end

endmodule

// File: tb/tb_prbs_ber_checker.sv
// Directed bench for prbs_ber_checker: default instance plus a 4-bit counter
// instance sharing the same stimulus for the saturation case.
module tb_prbs_ber_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic [1:0]  bits;
  logic        clear;
  logic [1:0]  lock;
  logic [63:0] bc;
  logic [63:0] ec;
  logic [1:0]  lock_s;
  logic [7:0]  bcs;
  logic [7:0]  ecs;

  int checks = 0;
  int errors = 0;

  logic [8:0] g0;
  logic [8:0] g1;

  always #5 clk = ~clk;

  prbs_ber_checker dut (
    .clk(clk), .i_reset(rst), .i_valid(valid), .i_bit(bits), .i_clear(clear),
    .o_lock(lock), .o_bit_cnt(bc), .o_err_cnt(ec)
  );

  prbs_ber_checker #(.NB_CNT(4)) dut_sat (
    .clk(clk), .i_reset(rst), .i_valid(valid), .i_bit(bits), .i_clear(clear),
    .o_lock(lock_s), .o_bit_cnt(bcs), .o_err_cnt(ecs)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One valid bit per call from the PRBS9 transmitters (x^9+x^5+1),
  // optionally inverted per channel; called and returns at a negedge.
  task automatic send(input logic [1:0] flip, input int gap, input logic clr);
    logic [1:0] b;
    b[0] = g0[8] ^ g0[4];
    b[1] = g1[8] ^ g1[4];
    g0 = {g0[7:0], b[0]};
    g1 = {g1[7:0], b[1]};
    valid = 1'b1;
    bits  = b ^ flip;
    clear = clr;
    @(negedge clk);
    valid = 1'b0;
    bits  = 2'b00;
    clear = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic run(input int n, input int gap);
    for (int i = 0; i < n; i++) send(2'b00, gap, 1'b0);
  endtask

  initial begin
    rst = 1'b1; valid = 1'b0; bits = 2'b00; clear = 1'b0;
    g0 = 9'h1AA; g1 = 9'h1FE;
    repeat (3) @(negedge clk);
    chk("reset_lock", 64'(lock), 64'd0);
    chk("reset_bitcnt", bc, 64'd0);
    chk("reset_errcnt", ec, 64'd0);
    chk("reset_sat_lock", 64'(lock_s), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Clean lock, valid every 4th cycle
    run(40, 3);
    chk("lock_bit40", 64'(lock), 64'd0);
    run(1, 3);
    chk("lock_bit41", 64'(lock), 64'(2'b11));
    chk("bitcnt_at_lock", bc, 64'd0);

    // Saturation of the 4-bit instance, back-to-back valids
    run(20, 0);
    chk("sat_lock", 64'(lock_s), 64'(2'b11));
    chk("sat_bitcnt", 64'(bcs), 64'(8'hFF));
    chk("sat_errcnt", 64'(ecs), 64'd0);
    run(980, 0);
    chk("clean_bit_ch0", 64'(bc[31:0]), 64'd1000);
    chk("clean_bit_ch1", 64'(bc[63:32]), 64'd1000);
    chk("clean_err", ec, 64'd0);
    chk("sat_bitcnt_hold", 64'(bcs), 64'(8'hFF));

    // Single error on ch0
    send(2'b01, 0, 1'b0);
    chk("single_err_ch0", 64'(ec[31:0]), 64'd1);
    chk("single_err_ch1", 64'(ec[63:32]), 64'd0);
    chk("single_lock", 64'(lock), 64'(2'b11));
    chk("single_bit_ch1", 64'(bc[63:32]), 64'd1001);

    // Clear while locked, alone and coinciding with a valid bit
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("clear_bit", bc, 64'd0);
    chk("clear_err", ec, 64'd0);
    chk("clear_lock", 64'(lock), 64'(2'b11));
    run(3, 0);
    chk("post_clear_bit", 64'(bc[31:0]), 64'd3);
    send(2'b00, 0, 1'b1);
    chk("clear_wins_bit", bc, 64'd0);
    run(5, 0);
    chk("count5_bit", 64'(bc[31:0]), 64'd5);

    // Burst of 65 ch0 errors inside one window
    repeat (64) send(2'b01, 0, 1'b0);
    chk("burst64_lock", 64'(lock), 64'(2'b11));
    chk("burst64_err", 64'(ec[31:0]), 64'd64);
    send(2'b01, 0, 1'b0);
    chk("burst65_err", 64'(ec[31:0]), 64'd65);
    chk("burst65_bit", 64'(bc[31:0]), 64'd70);
`ifdef BERCHK_AUTO_RESYNC_EN
    chk("burst65_lock", 64'(lock), 64'(2'b10));
    run(40, 0);
    chk("relock40_lock", 64'(lock), 64'(2'b10));
    chk("relock40_bit_hold", 64'(bc[31:0]), 64'd70);
    run(1, 0);
    chk("relock41_lock", 64'(lock), 64'(2'b11));
    chk("relock41_bit_hold", 64'(bc[31:0]), 64'd70);
    chk("relock41_err_hold", 64'(ec[31:0]), 64'd65);
`else
    chk("burst65_lock", 64'(lock), 64'(2'b11));
    run(41, 0);
    chk("sticky_lock", 64'(lock), 64'(2'b11));
    chk("sticky_bit", 64'(bc[31:0]), 64'd111);
    chk("sticky_err", 64'(ec[31:0]), 64'd65);
`endif
    chk("burst_ch1_err", 64'(ec[63:32]), 64'd0);
    chk("burst_ch1_bit", 64'(bc[63:32]), 64'd111);

    // Asynchronous reset mid-run, checked before any clock edge
    #2 rst = 1'b1;
    #1;
    chk("async_rst_lock", 64'(lock), 64'd0);
    chk("async_rst_bit", bc, 64'd0);
    chk("async_rst_err", ec, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Error during VERIFY on ch0
    run(20, 0);
    send(2'b01, 0, 1'b0);
    chk("verify_err_lock", 64'(lock), 64'd0);
    run(40, 0);
    chk("verify_relock40", 64'(lock), 64'(2'b10));
    run(1, 0);
    chk("verify_relock41", 64'(lock), 64'(2'b11));
    chk("verify_bit_ch0", 64'(bc[31:0]), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
